cache_arbiter: RTL and testbench

Shares the single 64-bit burst memory port between the instruction cache and the data cache inside the memory hierarchy. Each cache issues whole 256-bit line reads (I and D) or line write-backs (D only). The arbiter grants one requester at a time using round-robin, runs a 4-beat burst on the memory port, and assembles or serializes the line. It then returns a one-cycle response to the granted cache.

---
 rtl/cache_arbiter.sv | 134 +++++++++++++
 tb/tb_cache_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one 64-bit burst memory port between I-cache and D-cache line transfers.
// Latency: strobe one cycle after the grant in IDLE; resp one cycle after the 4th mem_resp; IDLE the cycle after that.
// Backpressure: each beat waits for mem_resp. Requests are sampled only in IDLE, so a new grant waits for the current burst to finish.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [31:0]  i_addr,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_addr,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_address,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_I_RD = 3'd1,
    S_D_RD = 3'd2,
    S_D_WR = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_beat;
  logic           r_last_d;   // 1: the most recent grant went to the D-cache
  logic [31:0]    r_addr;
  logic [255:0]   r_wline;
  logic [255:0]   r_i_line;
  logic [255:0]   r_d_line;

  logic           w_d_req;
  logic           w_grant_d;
  logic           w_grant_i;
  logic           w_busy;
  logic           w_last_beat;
  logic [7:0]     w_beat_lsb;
  logic           w_unused;

  // Arbitration: a lone requester wins; on a tie the side not granted last wins.
  assign w_d_req     = d_read | d_write;
  assign w_grant_d   = w_d_req & (~i_read | ~r_last_d);
  assign w_grant_i   = i_read & ~w_grant_d;
  assign w_busy      = (r_state == S_I_RD) | (r_state == S_D_RD) | (r_state == S_D_WR);
  assign w_last_beat = mem_resp & (r_beat == 2'd3);
  assign w_beat_lsb  = {r_beat, 6'd0};

  // The line offset bits are ignored; this keeps the unused-input lint quiet.
  assign w_unused = ^{i_addr[4:0], d_addr[4:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. d_write beats d_read if both are raised.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_next = d_write ? S_D_WR : S_D_RD;
        end else if (w_grant_i) begin
          w_next = S_I_RD;
        end
      end
      S_I_RD, S_D_RD, S_D_WR: begin
        if (w_last_beat) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch grant context in IDLE, then count beats and assemble read lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat   <= 2'd0;
      r_last_d <= 1'b0;
      r_addr   <= 32'd0;
      r_wline  <= 256'd0;
      r_i_line <= 256'd0;
      r_d_line <= 256'd0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_grant_d | w_grant_i) begin
          r_addr   <= w_grant_d ? {d_addr[31:5], 5'd0} : {i_addr[31:5], 5'd0};
          r_beat   <= 2'd0;
          r_last_d <= w_grant_d;
        end
        if (w_grant_d & d_write) begin
          r_wline <= d_wdata;
        end
      end else if (w_busy & mem_resp) begin
        r_beat <= r_beat + 2'd1;
        if (r_state == S_I_RD) begin
          r_i_line[w_beat_lsb +: 64] <= mem_rdata;
        end
        if (r_state == S_D_RD) begin
          r_d_line[w_beat_lsb +: 64] <= mem_rdata;
        end
      end
    end
  end

  // Outputs: strobes and resp pulses decode the state; data comes straight from registers.
  always_comb begin
    mem_read    = (r_state == S_I_RD) | (r_state == S_D_RD);
    mem_write   = (r_state == S_D_WR);
    mem_address = r_addr;
    mem_wdata   = r_wline[w_beat_lsb +: 64];
    i_resp      = (r_state == S_DONE) & ~r_last_d;
    d_resp      = (r_state == S_DONE) & r_last_d;
    i_rdata     = r_i_line;
    d_rdata     = r_d_line;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: drives requests and memory beats on the falling edge and checks outputs there.
// Latency: expectations are written for the one-cycle grant-to-strobe path and the one-cycle DONE pulse.
// Backpressure: the bench memory inserts configurable idle cycles between beats.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_chk = 0;
  int n_err = 0;

  cache_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_read      (i_read),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line pattern tied to its address so each read response can be told apart.
  function automatic logic [255:0] mkline(input logic [31:0] a);
    logic [255:0] l;
    l = '0;
    for (int b = 0; b < 4; b++) begin
      l[b*64 +: 64] = {a, 28'hA5A5A5A, b[3:0]};
    end
    return l;
  endfunction

  // Memory side of one burst: wait for a strobe, answer 4 beats with 'gap' idle cycles between them.
  task automatic serve(input int gap, input logic is_wr, input logic [255:0] rline,
                       input logic [255:0] exp_w, output logic [31:0] addr_seen, output int waited);
    waited = 0;
    while (!(mem_read || mem_write) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) chk("strobe_timeout", 256'd0, 256'd1);
    addr_seen = mem_address;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < ((b == 0) ? 0 : gap); g++) begin
        mem_resp = 1'b0;
        @(negedge clk);
        chk("strobe_hold", 256'(is_wr ? mem_write : mem_read), 256'd1);
        if (is_wr) chk("wdata_hold", 256'(mem_wdata), 256'(exp_w[b*64 +: 64]));
      end
      chk("strobe", 256'(is_wr ? mem_write : mem_read), 256'd1);
      chk("no_overlap", 256'(mem_read & mem_write), 256'd0);
      chk("addr_stable", 256'(mem_address), 256'(addr_seen));
      if (is_wr) chk("wdata", 256'(mem_wdata), 256'(exp_w[b*64 +: 64]));
      mem_rdata = rline[b*64 +: 64];
      mem_resp  = 1'b1;
      @(negedge clk);
    end
    mem_resp  = 1'b0;
    mem_rdata = 64'd0;
    chk("strobe_drop", 256'({mem_read, mem_write}), 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  a;
    int           w;
    logic [255:0] l1;
    logic [255:0] wl;
    logic [255:0] wl2;
    logic         is_d;

    rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_read",  256'(mem_read), 256'd0);
    chk("rst_mem_write", 256'(mem_write), 256'd0);
    chk("rst_mem_addr",  256'(mem_address), 256'd0);
    chk("rst_mem_wdata", 256'(mem_wdata), 256'd0);
    chk("rst_i_resp",    256'(i_resp), 256'd0);
    chk("rst_d_resp",    256'(d_resp), 256'd0);
    chk("rst_i_rdata",   i_rdata, 256'd0);
    chk("rst_d_rdata",   d_rdata, 256'd0);
    rst = 1'b0;

    // Stray mem_resp while idle must do nothing.
    mem_resp = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_resp_strobe", 256'({mem_read, mem_write}), 256'd0);
      chk("idle_resp_resp",   256'({i_resp, d_resp}), 256'd0);
    end
    mem_resp = 1'b0; mem_rdata = 64'd0;

    // I read alone.
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    i_read = 1'b1; i_addr = 32'h0000_1234;
    @(negedge clk);
    chk("i_latency", 256'(mem_read), 256'd1);
    serve(0, 1'b0, l1, 256'd0, a, w);
    chk("i_addr", 256'(a), 256'h0000_1220);
    chk("i_resp_pulse", 256'(i_resp), 256'd1);
    chk("i_no_d_resp",  256'(d_resp), 256'd0);
    i_read = 1'b0;
    @(negedge clk);
    chk("i_resp_one", 256'(i_resp), 256'd0);
    chk("i_rdata", i_rdata, l1);

    // D write-back with 2 idle cycles between beats.
    wl = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
          64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    d_write = 1'b1; d_addr = 32'h8000_0040; d_wdata = wl;
    serve(2, 1'b1, 256'd0, wl, a, w);
    chk("dw_addr", 256'(a), 256'h8000_0040);
    chk("dw_resp", 256'(d_resp), 256'd1);
    chk("dw_no_i_resp", 256'(i_resp), 256'd0);
    d_write = 1'b0;
    @(negedge clk);
    chk("dw_resp_one", 256'(d_resp), 256'd0);

    // d_read with d_write is treated as a write-back; d_rdata is untouched.
    wl2 = {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000};
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_0055; d_wdata = wl2;
    serve(0, 1'b1, 256'd0, wl2, a, w);
    chk("ill_addr", 256'(a), 256'h0000_0040);
    chk("ill_resp", 256'(d_resp), 256'd1);
    d_read = 1'b0; d_write = 1'b0;
    @(negedge clk);
    chk("ill_d_rdata", d_rdata, 256'd0);

    // Simultaneous requests after reset: D, I, D, I.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
    i_read = 1'b1; d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      is_d = (k % 2 == 0);
      serve(k % 2, 1'b0, mkline(is_d ? d_addr : i_addr), 256'd0, a, w);
      chk("tie_wait", 256'(w), 256'd1);
      chk("tie_addr", 256'(a), 256'(is_d ? d_addr : i_addr));
      chk("tie_i_resp", 256'(i_resp), 256'(!is_d));
      chk("tie_d_resp", 256'(d_resp), 256'(is_d));
      if (is_d) d_read = 1'b0; else i_read = 1'b0;
      if (k == 3) d_read = 1'b0;
      @(negedge clk);
      chk("tie_resp_drop", 256'({i_resp, d_resp}), 256'd0);
      chk("tie_strobe_idle", 256'({mem_read, mem_write}), 256'd0);
      if (is_d) chk("tie_d_rdata", d_rdata, mkline(d_addr));
      else      chk("tie_i_rdata", i_rdata, mkline(i_addr));
      if (k < 3) begin
        if (is_d) d_read = 1'b1; else i_read = 1'b1;
      end
    end

    // Reset after beat 1 of an I read, then a clean retry.
    i_read = 1'b1; i_addr = 32'h0000_3000;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      mem_resp = 1'b1; mem_rdata = 64'hBAD0_0000_0000_0000 | 64'(b);
      @(negedge clk);
    end
    rst = 1'b1; mem_resp = 1'b0; mem_rdata = 64'd0; i_read = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_read", 256'(mem_read), 256'd0);
    chk("mid_rst_i_resp",   256'(i_resp), 256'd0);
    chk("mid_rst_i_rdata",  i_rdata, 256'd0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 256'({mem_read, i_resp, d_resp}), 256'd0);
    end
    i_read = 1'b1;
    serve(1, 1'b0, mkline(32'h0000_3000), 256'd0, a, w);
    chk("retry_addr", 256'(a), 256'h0000_3000);
    chk("retry_resp", 256'(i_resp), 256'd1);
    i_read = 1'b0;
    @(negedge clk);
    chk("retry_rdata", i_rdata, mkline(32'h0000_3000));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
